// File: rtl/mix_pkg.sv
// mix_pkg: shared widths, frame/word types and the digest rotate for the mixer output stage.
package mix_pkg;
  localparam int WORD_W = 32;
  localparam int N_WORDS = 8;
  localparam int IDX_W = $clog2(N_WORDS);
  localparam int FRAME_W = N_WORDS * WORD_W;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [FRAME_W-1:0] frame_t;
  function automatic word_t rotl5(input word_t w);
    return {w[WORD_W-6:0], w[WORD_W-1:WORD_W-5]};
  endfunction
endpackage

// File: rtl/mix_frame_fifo.sv
// mix_frame_fifo: DEPTH-entry register FIFO of whole frames with registered ready/empty flags.
module mix_frame_fifo
  import mix_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  logic   pop_i,
  input  frame_t data_i,
  output frame_t data_o,
  output logic   ready_o,
  output logic   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  frame_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [OW-1:0] occ_q, occ_d;
  logic ready_q, empty_q;
  assign occ_d = occ_q + OW'(push_i) - OW'(pop_i);
  assign data_o = mem_q[rd_q];
  assign ready_o = ready_q;
  assign empty_o = empty_q;
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  // ready stays low through reset and rises on the first clock after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
      ready_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i) rd_q <= rd_q + PW'(1);
      occ_q <= occ_d;
      ready_q <= occ_d < OW'(DEPTH);
      empty_q <= occ_d == '0;
    end
  end
endmodule

// File: rtl/mix_frame_serializer.sv
// mix_frame_serializer: buffers mixer frames and streams them word by word,
// folding each frame into a digest and counting completed frames.
module mix_frame_serializer
  import mix_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_WORDS*WORD_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic                      digest_valid,
  output logic [WORD_W-1:0]         digest,
  output logic [CNT_W-1:0]          frame_cnt
);
  frame_t head;
  logic empty, push, xfer, last, done, dv_q;
  word_t word, fold, acc_q, acc_d, digest_q, digest_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign push = in_valid && in_ready;
  mix_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(done),
    .data_i(in_data),
    .data_o(head),
    .ready_o(in_ready),
    .empty_o(empty)
  );
  always_comb begin
    out_valid = !empty;
    last = idx_q == IDX_W'(N_WORDS - 1);
    word = head[idx_q*WORD_W +: WORD_W];
    xfer = out_valid && out_ready;
    done = xfer && last;
    fold = rotl5(acc_q) ^ word;
    idx_d = xfer ? idx_q + IDX_W'(1) : idx_q;
    acc_d = done ? '0 : xfer ? fold : acc_q;
    digest_d = done ? fold : digest_q;
    cnt_d = cnt_q + CNT_W'(done);
  end
  // word is masked so stale buffer contents never leak while empty
  assign out_data = out_valid ? word : '0;
  assign out_idx = idx_q;
  assign out_last = out_valid && last;
  assign digest_valid = dv_q;
  assign digest = digest_q;
  assign frame_cnt = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      acc_q <= '0;
      digest_q <= '0;
      dv_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
      digest_q <= digest_d;
      dv_q <= done;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mix_frame_serializer.sv
// tb_mix_frame_serializer: directed bench with a frame-queue reference model checked every cycle.
module tb_mix_frame_serializer;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [255:0] in_data = '0;
  logic in_ready, out_valid, out_last, digest_valid;
  logic [31:0] out_data, digest;
  logic [2:0] out_idx;
  logic [15:0] frame_cnt;
  logic in_ready_s, out_valid_s, out_last_s, digest_valid_s;
  logic [31:0] out_data_s, digest_s;
  logic [2:0] out_idx_s;
  logic [3:0] frame_cnt_s;
  int vectors = 0, errors = 0;

  mix_frame_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .digest_valid(digest_valid), .digest(digest), .frame_cnt(frame_cnt)
  );
  // narrow-counter copy sees the same traffic so counter wrap is reachable quickly
  mix_frame_serializer #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_idx(out_idx_s),
    .out_last(out_last_s), .digest_valid(digest_valid_s), .digest(digest_s), .frame_cnt(frame_cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fold(input logic [255:0] f);
    logic [31:0] d = '0;
    for (int k = 0; k < 8; k++) d = {d[26:0], d[31:27]} ^ f[k*32 +: 32];
    return d;
  endfunction

  function automatic logic [255:0] rnd_frame();
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = $urandom;
    return f;
  endfunction

  logic [255:0] mq[$];
  int midx = 0, mcnt = 0;
  logic [31:0] mdig = '0;
  bit mdv = 0, mrdy = 0, mpush = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      midx = 0; mcnt = 0; mdig = '0; mdv = 0; mrdy = 0;
    end else begin
      mpush = in_valid && mrdy && mq.size() < 2;
      mdv = 0;
      if (mq.size() != 0 && out_ready) begin
        if (midx == 7) begin
          mdig = fold(mq[0]);
          mdv = 1;
          mcnt++;
          void'(mq.pop_front());
          midx = 0;
        end else midx++;
      end
      if (mpush) mq.push_back(in_data);
      mrdy = 1;
    end
  end

  bit stalled = 0;
  logic [34:0] held = '0;
  always @(negedge clk) begin
    logic [31:0] ew;
    logic has;
    has = mq.size() != 0;
    ew = has ? mq[0][midx*32 +: 32] : 32'h0;
    chk("in_ready", in_ready, mrdy && mq.size() < 2);
    chk("out_valid", out_valid, has);
    chk("out_data", out_data, ew);
    chk("out_idx", out_idx, midx);
    chk("out_last", out_last, has && midx == 7);
    chk("digest_valid", digest_valid, mdv);
    chk("digest", digest, mdig);
    chk("frame_cnt", frame_cnt, mcnt % 65536);
    chk("frame_cnt_s", frame_cnt_s, mcnt % 16);
    chk("small_flags", {in_ready_s, out_valid_s, out_last_s, digest_valid_s, out_idx_s},
        {mrdy && mq.size() < 2, has, has && midx == 7, mdv, 3'(midx)});
    chk("small_words", {out_data_s, digest_s}, {ew, mdig});
    if (stalled && !rst) chk("stall_hold", {out_idx, out_data}, held);
    stalled = out_valid && !out_ready && !rst;
    held = {out_idx, out_data};
  end

  task automatic push(input logic [255:0] f);
    int n = 0;
    logic r;
    in_valid = 1'b1;
    in_data = f;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 300);
    in_valid = 1'b0;
    if (!r) begin
      vectors++; errors++;
      $display("FAIL push_timeout: in_ready never rose within %0d cycles", n);
    end
  endtask

  task automatic wait_digest(input logic [31:0] exp, input string nm);
    int n = 0;
    bit seen = 0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      seen = digest_valid;
      n++;
    end
    if (seen) chk(nm, digest, exp);
    else begin
      vectors++; errors++;
      $display("FAIL %s: digest_valid missing after %0d cycles", nm, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] f;
    int n;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    // single frame 1,0,...,0
    out_ready = 1'b1;
    f = '0;
    f[31:0] = 32'h1;
    push(f);
    chk("t1_latency", {out_valid, out_idx}, {1'b1, 3'd0});
    chk("t1_word0", out_data, 32'h1);
    wait_digest(32'h0000_0008, "t1_digest");
    chk("t1_cnt", frame_cnt, 1);
    // all-ones and all-zeros frames
    push({256{1'b1}});
    wait_digest(32'h0, "t2_ones_digest");
    push('0);
    wait_digest(32'h0, "t2_zero_digest");
    chk("t2_cnt", frame_cnt, 3);
    // fill with consumer stalled, third frame held off
    out_ready = 1'b0;
    push(rnd_frame());
    push(rnd_frame());
    fork
      push(rnd_frame());
      begin
        repeat (4) @(negedge clk);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_held_idx", out_idx, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    #1;
    chk("t3_cnt", frame_cnt, 6);
    // random consumer stalls
    fork
      for (int i = 0; i < 4; i++) push(rnd_frame());
      for (int i = 0; i < 90; i++) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t4_cnt", frame_cnt, 10);
    // reset mid-frame with one frame queued
    push(rnd_frame());
    push(rnd_frame());
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_idx != 3'd4 && n < 50);
    chk("t5_reached_idx4", out_idx, 4);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_outs", {in_ready, out_valid, out_last, digest_valid, out_idx}, 0);
    chk("t5_rst_data", {out_data, frame_cnt}, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_release_ready", in_ready, 1);
    chk("t5_release_cnt", frame_cnt, 0);
    @(posedge clk);
    #1;
    // 16 back-to-back frames wrap the narrow counter
    for (int i = 0; i < 16; i++) push(rnd_frame());
    repeat (40) @(posedge clk);
    #1;
    chk("t6_cnt", frame_cnt, 16);
    chk("t6_wrap_cnt_s", frame_cnt_s, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
